// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sequencer: ALU opcodes, the MUL macro-opcode,
// flag bit positions and the sequencer state encoding.
package alu_pkg;

  // ALU opcodes used by the sequencer (the ALU decodes 6'b000001..6'b010011)
  localparam logic [5:0] OP_NOP   = 6'b000000;
  localparam logic [5:0] OP_ADD   = 6'b000001;
  localparam logic [5:0] OP_ASL_D = 6'b001100;
  localparam logic [5:0] OP_LAST  = 6'b010011;

  // Macro-opcode handled by the sequencer itself, never sent to the ALU
  localparam logic [5:0] OP_MUL   = 6'b100000;

  // Flag vector layout {carry, negative, zero, overflow}
  localparam int FLG_C = 3;
  localparam int FLG_N = 2;
  localparam int FLG_Z = 1;
  localparam int FLG_V = 0;

  // Sequencer states
  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE      = 3'd0;
  localparam state_t ST_EXEC      = 3'd1;
  localparam state_t ST_MUL_ADD   = 3'd2;
  localparam state_t ST_MUL_SHIFT = 3'd3;
  localparam state_t ST_DONE      = 3'd4;

endpackage

// File: rtl/alu_seq_ctrl.sv
// Sequencer in front of the shared combinational ALU.
// Single ALU opcodes are issued for one cycle and their result/flags captured.
// The MUL macro-opcode runs a shift-add multiply that reuses the ALU's ADD and
// arithmetic-shift-left-D operations, one multiplier bit per ADD/SHIFT pair.
//
// Ports:
//   clk, rst_n                        clock, asynchronous active-low reset
//   in_valid/in_ready, in_op/d/m      request handshake and operands
//   out_valid/out_ready               result handshake (held until out_ready)
//   out_result, out_flags             result and {carry/uovf, neg, zero, ovf}
//   alu_opcode/alu_d/alu_m            drive to the ALU (0 when idle)
//   alu_result/alu_flags              combinational ALU response
module alu_seq_ctrl
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [5:0]       in_op,
  input  logic [WIDTH-1:0] in_d,
  input  logic [WIDTH-1:0] in_m,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [3:0]       out_flags,
  output logic [5:0]       alu_opcode,
  output logic [WIDTH-1:0] alu_d,
  output logic [WIDTH-1:0] alu_m,
  input  logic [WIDTH-1:0] alu_result,
  input  logic [3:0]       alu_flags
);

  state_t           state;
  logic [5:0]       op_q;
  logic [WIDTH-1:0] d_q;
  logic [WIDTH-1:0] m_q;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [3:0]       cnt;
  logic             uovf;

  logic [WIDTH-1:0] mplier_nxt;
  logic             mul_last;
  logic             uovf_shift;

  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);

  assign mplier_nxt = mplier >> 1;
  assign mul_last   = (mplier_nxt == '0) || (cnt == 4'd15);
  // A set top bit shifted out of the multiplicand is lost; it would have been
  // part of a later partial product whenever multiplier bits remain.
  assign uovf_shift = uovf | (mcand[WIDTH-1] & (mplier_nxt != '0));

  // ALU drive: zero whenever the ALU result is not consumed
  always_comb begin
    alu_opcode = OP_NOP;
    alu_d      = '0;
    alu_m      = '0;
    case (state)
      ST_EXEC: begin
        alu_opcode = op_q;
        alu_d      = d_q;
        alu_m      = m_q;
      end
      ST_MUL_ADD: begin
        if (mplier[0]) begin
          alu_opcode = OP_ADD;
          alu_d      = acc;
          alu_m      = mcand;
        end
      end
      ST_MUL_SHIFT: begin
        alu_opcode = OP_ASL_D;
        alu_d      = mcand;
        alu_m      = '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      op_q       <= '0;
      d_q        <= '0;
      m_q        <= '0;
      acc        <= '0;
      mcand      <= '0;
      mplier     <= '0;
      cnt        <= '0;
      uovf       <= 1'b0;
      out_result <= '0;
      out_flags  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            op_q <= in_op;
            d_q  <= in_d;
            m_q  <= in_m;
            if (in_op == OP_MUL) begin
              acc    <= '0;
              mcand  <= in_d;
              mplier <= in_m;
              cnt    <= '0;
              uovf   <= 1'b0;
              state  <= ST_MUL_ADD;
            end else begin
              state <= ST_EXEC;
            end
          end
        end

        ST_EXEC: begin
          out_result <= alu_result;
          out_flags  <= alu_flags;
          state      <= ST_DONE;
        end

        ST_MUL_ADD: begin
          // Carry out of the accumulate means the true sum exceeded WIDTH bits
          if (mplier[0]) begin
            acc  <= alu_result;
            uovf <= uovf | alu_flags[FLG_C];
          end
          state <= ST_MUL_SHIFT;
        end

        ST_MUL_SHIFT: begin
          mcand  <= alu_result;
          mplier <= mplier_nxt;
          cnt    <= cnt + 4'd1;
          uovf   <= uovf_shift;
          if (mul_last) begin
            out_result <= acc;
            out_flags  <= {uovf_shift, acc[WIDTH-1], (acc == '0), 1'b0};
            state      <= ST_DONE;
          end else begin
            state <= ST_MUL_ADD;
          end
        end

        ST_DONE: begin
          if (out_ready) begin
            state <= ST_IDLE;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
